// File: rtl/i2c_pkg.sv
// Shared types and helpers for the I2C read scheduler.
// State encoding, default bus widths and a one-hot helper.
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam int AW_DEF = 7;
  localparam int DW_DEF = 8;
  localparam int N_MAX  = 8;

  function automatic logic [N_MAX-1:0] onehot(input logic [2:0] idx);
    onehot = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr+1 upward with wrap.
// Returns one-hot grant, winner index and an any-request flag.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any = 1'b1;
        idx = IW'(j);
      end
    end
    if (any) gnt = N'(1) << idx;
  end

endmodule

// File: rtl/i2c_read_sched.sv
// Round-robin scheduler of N sensor reads onto one I2C read master.
// Optional watchdog on the master: define I2C_SCHED_TIMEOUT_EN.
module i2c_read_sched
  import i2c_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int AW          = AW_DEF,
  parameter int DW          = DW_DEF,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*AW-1:0] req_addr,
  output logic [N_REQ-1:0]    grant,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]       rsp_data,
  output logic                rsp_err,
  output logic                m_start,
  output logic [AW-1:0]       m_addr,
  input  logic                m_busy,
  input  logic                m_done,
  input  logic [DW-1:0]       m_data,
  input  logic                m_nack,
  output logic                busy
);

  localparam int IW = $clog2(N_REQ);

  state_t          state;
  logic [IW-1:0]   sel;
  logic [IW-1:0]   rr;
  logic [N_REQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_arb (
    .req (req),
    .ptr (rr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be positive");
  end

`ifdef I2C_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= '0;
      rr        <= IW'(N_REQ - 1);
      grant     <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      m_start   <= 1'b0;
      m_addr    <= '0;
      busy      <= 1'b0;
`ifdef I2C_SCHED_TIMEOUT_EN
      cnt       <= '0;
`endif
    end else begin
      m_start   <= 1'b0;
      rsp_valid <= '0;
      unique case (state)
        IDLE: begin
          if (arb_any) begin
            sel    <= arb_idx;
            grant  <= arb_gnt;
            m_addr <= req_addr[arb_idx*AW +: AW];
            busy   <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (!m_busy) begin
            m_start <= 1'b1;
            state   <= WAIT;
`ifdef I2C_SCHED_TIMEOUT_EN
            cnt     <= '0;
`endif
          end
        end
        WAIT: begin
          if (m_done) begin
            rsp_data  <= m_data;
            rsp_err   <= m_nack;
            rsp_valid <= N_REQ'(onehot(3'(sel)));
            state     <= RESP;
`ifdef I2C_SCHED_TIMEOUT_EN
          end else if (cnt == CW'(TIMEOUT_CYC)) begin
            // Master hung: answer with an error so the client never stalls
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= N_REQ'(onehot(3'(sel)));
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
`endif
          end
        end
        RESP: begin
          rr    <= sel;
          grant <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
